// File: rtl/store_v_rotator.sv
// Givens rotation of one V-matrix row pair: read both rows, rotate every lane
// in Q8.16 with saturation, then write both rows back in a single access.
module store_v_rotator #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 16,
    parameter int LANES  = 8,
    parameter int ADDR_W = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [1:0]                    row_sel,
    input  logic [DATA_W-1:0]             cos_in,
    input  logic [DATA_W-1:0]             sin_in,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_W-1:0]             st_addr,
    output logic                          st_we,
    output logic [2*LANES*DATA_W-1:0]     st_wdata,
    input  logic [2*LANES*DATA_W-1:0]     st_rdata
);

    localparam int SW = 2*DATA_W + 1;
    localparam int ROW_W = LANES*DATA_W;
    localparam logic signed [SW-1:0] ONE  = 1;
    localparam logic signed [SW-1:0] MAXV = (ONE <<< (DATA_W-1)) - ONE;
    localparam logic signed [SW-1:0] MINV = -(ONE <<< (DATA_W-1));
    localparam logic [ADDR_W-1:0] ADDR_OFF = {1'b1, {(ADDR_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, RD, CAP, CALC, WR, FIN} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                row_q;
    logic signed [DATA_W-1:0]  cos_q, sin_q;
    logic                      err_q;
    logic signed [DATA_W-1:0]  h_q [LANES];
    logic signed [DATA_W-1:0]  l_q [LANES];
    logic [2*ROW_W-1:0]        wdata_q, wdata_d;

    logic signed [2*DATA_W-1:0] p_ch [LANES];
    logic signed [2*DATA_W-1:0] p_sl [LANES];
    logic signed [2*DATA_W-1:0] p_sh [LANES];
    logic signed [2*DATA_W-1:0] p_cl [LANES];
    logic signed [SW-1:0]       h_sum [LANES];
    logic signed [SW-1:0]       l_sum [LANES];

    // Shift floors toward -inf, then clamp into the 24-bit signed range.
    function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] s;
        s = v >>> FRAC_W;
        if (s > MAXV)
            return MAXV[DATA_W-1:0];
        else if (s < MINV)
            return MINV[DATA_W-1:0];
        else
            return s[DATA_W-1:0];
    endfunction

    always_comb begin
        wdata_d = '0;
        for (int i = 0; i < LANES; i++) begin
            p_ch[i]  = (2*DATA_W)'(cos_q) * (2*DATA_W)'(h_q[i]);
            p_sl[i]  = (2*DATA_W)'(sin_q) * (2*DATA_W)'(l_q[i]);
            p_sh[i]  = (2*DATA_W)'(sin_q) * (2*DATA_W)'(h_q[i]);
            p_cl[i]  = (2*DATA_W)'(cos_q) * (2*DATA_W)'(l_q[i]);
            h_sum[i] = SW'(p_ch[i]) - SW'(p_sl[i]);
            l_sum[i] = SW'(p_sh[i]) + SW'(p_cl[i]);
            wdata_d[i*DATA_W +: DATA_W]         = sat(h_sum[i]);
            wdata_d[ROW_W + i*DATA_W +: DATA_W] = sat(l_sum[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        st_we   = 1'b0;
        st_addr = ADDR_OFF;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = (row_sel == 2'd3) ? FIN : RD;
            end
            RD: begin
                busy    = 1'b1;
                st_addr = {{(ADDR_W-2){1'b0}}, row_q};
                state_d = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                busy    = 1'b1;
                state_d = WR;
            end
            WR: begin
                busy    = 1'b1;
                st_we   = 1'b1;
                st_addr = {{(ADDR_W-2){1'b0}}, row_q};
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                h_q[i] <= '0;
                l_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                err_q <= (row_sel == 2'd3);
                if (row_sel != 2'd3) begin
                    row_q <= row_sel;
                    cos_q <= cos_in;
                    sin_q <= sin_in;
                end
            end
            if (state_q == CAP) begin
                for (int i = 0; i < LANES; i++) begin
                    h_q[i] <= st_rdata[i*DATA_W +: DATA_W];
                    l_q[i] <= st_rdata[ROW_W + i*DATA_W +: DATA_W];
                end
            end
            if (state_q == CALC)
                wdata_q <= wdata_d;
        end
    end

    assign st_wdata = wdata_q;

endmodule

// File: tb/tb_store_v_rotator.sv
// Directed bench for store_v_rotator with a behavioural row-pair store model.
module tb_store_v_rotator;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   row_sel = '0;
    logic [23:0]  cos_in = '0;
    logic [23:0]  sin_in = '0;
    logic         busy, done, err, st_we;
    logic [5:0]   st_addr;
    logic [383:0] st_wdata;
    logic [383:0] st_rdata = '0;

    logic [191:0] mem [4];
    int checks = 0;
    int failures = 0;
    int dn, wrn, rdn, wcnt, bcnt;
    logic errv;

    store_v_rotator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_sel(row_sel),
        .cos_in(cos_in), .sin_in(sin_in), .busy(busy), .done(done),
        .err(err), .st_addr(st_addr), .st_we(st_we),
        .st_wdata(st_wdata), .st_rdata(st_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!st_addr[5]) begin
            if (st_we) begin
                mem[st_addr[1:0]]      <= st_wdata[191:0];
                mem[st_addr[1:0] + 1]  <= st_wdata[383:192];
            end else begin
                st_rdata <= {mem[st_addr[1:0] + 1], mem[st_addr[1:0]]};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] lane(input logic [191:0] r, input int i);
        return r[i*24 +: 24];
    endfunction

    task automatic fill(input int r, input logic [23:0] v);
        for (int i = 0; i < 8; i++) mem[r][i*24 +: 24] = v;
    endtask

    // Issue one command and watch 12 cycles; poke re-strobes start, rst_at pulls reset.
    task automatic cmd(input logic [1:0] r, input logic [23:0] c,
                       input logic [23:0] s, input int poke, input int rst_at);
        dn = -1; wrn = -1; rdn = -1; wcnt = 0; bcnt = 0; errv = 1'b0;
        @(negedge clk);
        row_sel = r; cos_in = c; sin_in = s; start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = (n == poke);
            if (n == rst_at) rst_n = 1'b0;
            if (n == rst_at + 1) rst_n = 1'b1;
            if (!st_addr[5] && st_we) begin
                wcnt++;
                if (wrn < 0) wrn = n;
            end
            if (!st_addr[5] && !st_we && rdn < 0) rdn = n;
            if (busy) bcnt++;
            if (done && dn < 0) begin
                dn = n;
                errv = err;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_we", 32'(st_we), 0);
        chk("rst_addr", 32'(st_addr), 32'h20);
        chk("rst_wdata", 32'(st_wdata != '0), 0);
        rst_n = 1'b1;

        // identity pass-through on rows 0/1
        for (int i = 0; i < 4; i++) mem[i] = '0;
        mem[0][0*24 +: 24] = 24'h010000;
        mem[1][1*24 +: 24] = 24'h010000;
        mem[2][2*24 +: 24] = 24'h010000;
        cmd(2'd0, 24'h010000, 24'h0, -1, -1);
        chk("id_done_cyc", 32'(dn), 5);
        chk("id_err", 32'(errv), 0);
        chk("id_rd_cyc", 32'(rdn), 1);
        chk("id_wr_cyc", 32'(wrn), 4);
        chk("id_busy_cyc", 32'(bcnt), 4);
        chk("id_h0", 32'(lane(mem[0], 0)), 32'h010000);
        chk("id_h1", 32'(lane(mem[0], 1)), 0);
        chk("id_l1", 32'(lane(mem[1], 1)), 32'h010000);
        chk("id_l0", 32'(lane(mem[1], 0)), 0);
        chk("id_row2", 32'(lane(mem[2], 2)), 32'h010000);

        // 90 degrees on rows 1/2
        for (int i = 0; i < 8; i++) begin
            mem[1][i*24 +: 24] = 24'((i+1) * 65536);
            mem[2][i*24 +: 24] = 24'(-(i+1) * 65536);
        end
        cmd(2'd1, 24'h0, 24'h010000, -1, -1);
        chk("r90_done_cyc", 32'(dn), 5);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("r90_h%0d", i), 32'(lane(mem[1], i)), 32'((i+1) * 65536));
            chk($sformatf("r90_l%0d", i), 32'(lane(mem[2], i)), 32'((i+1) * 65536));
        end

        // saturation high
        fill(0, 24'h640000);
        fill(1, 24'h640000);
        cmd(2'd0, 24'h010000, 24'h010000, -1, -1);
        chk("sat_h", 32'(lane(mem[0], 3)), 32'h000000);
        chk("sat_l", 32'(lane(mem[1], 7)), 32'h7FFFFF);

        // saturation low
        fill(0, 24'h9C0000);
        fill(1, 24'h640000);
        cmd(2'd0, 24'h010000, 24'h010000, -1, -1);
        chk("satn_h", 32'(lane(mem[0], 5)), 32'h800000);
        chk("satn_l", 32'(lane(mem[1], 0)), 32'h000000);

        // floor of +1 LSB * 0.5
        fill(2, 24'h000001);
        fill(3, 24'h0);
        cmd(2'd2, 24'h008000, 24'h0, -1, -1);
        chk("rnd_pos_h", 32'(lane(mem[2], 2)), 32'h000000);
        chk("rnd_pos_l", 32'(lane(mem[3], 2)), 32'h000000);

        // floor of -1 LSB * 0.5
        fill(2, 24'hFFFFFF);
        cmd(2'd2, 24'h008000, 24'h0, -1, -1);
        chk("rnd_neg_h", 32'(lane(mem[2], 6)), 32'hFFFFFF);
        chk("rnd_neg_l", 32'(lane(mem[3], 6)), 32'h000000);

        // reject row 3
        cmd(2'd3, 24'h010000, 24'h0, -1, -1);
        chk("rej_done_cyc", 32'(dn), 1);
        chk("rej_err", 32'(errv), 1);
        chk("rej_rd", 32'(rdn), 32'hFFFFFFFF);
        chk("rej_wr", 32'(wrn), 32'hFFFFFFFF);
        chk("rej_busy", 32'(bcnt), 0);

        // normal command after reject clears err
        fill(0, 24'h020000);
        fill(1, 24'h030000);
        cmd(2'd0, 24'h010000, 24'h0, 3, -1);
        chk("poke_writes", 32'(wcnt), 1);
        chk("poke_err", 32'(errv), 0);
        chk("poke_done_cyc", 32'(dn), 5);
        chk("poke_h", 32'(lane(mem[0], 4)), 32'h020000);

        // reset in CAP aborts
        fill(0, 24'h050000);
        cmd(2'd0, 24'h0, 24'h010000, -1, 2);
        chk("abort_writes", 32'(wcnt), 0);
        chk("abort_done", 32'(dn), 32'hFFFFFFFF);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_addr", 32'(st_addr), 32'h20);
        chk("abort_wdata", 32'(st_wdata != '0), 0);
        chk("abort_mem", 32'(lane(mem[0], 1)), 32'h050000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
